pot_scan_seq: RTL and testbench

- Scheduler that time-shares the single SPI A2D master among the six slide pots: LP, B1, B2, B3, HP and volume.
- Issues conversions round-robin with a programmable gap between them.
- Captures each 12-bit result into a dedicated holding register that feeds the band-gain and volume datapath.
- Sits between the A2D SPI master (talks to ADC128S) and the equalizer gain stages.

---
 rtl/pot_scan_seq.sv | 180 ++++++++++++++++++
 tb/tb_pot_scan_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pot_scan_seq.sv
// pot_scan_seq: round-robin A2D conversion scheduler for the six slide pots.
// Optional: define POT_SMOOTH_EN for 1/4-weight IIR smoothing of captures.
module pot_scan_seq #(
  parameter int GAP_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic [11:0] LP_pot,
  output logic [11:0] B1_pot,
  output logic [11:0] B2_pot,
  output logic [11:0] B3_pot,
  output logic [11:0] HP_pot,
  output logic [11:0] volume,
  output logic        sweep_done
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    GAP
  } state_t;

  localparam logic [15:0] GAP_LD = 16'(GAP_CYCLES - 1);

  state_t      r_state;
  state_t      w_nxt;
  logic [2:0]  r_idx;
  logic [15:0] r_gap;
  logic        r_sweep;
  logic [11:0] r_pot [6];
  logic        w_cap;
  logic [11:0] w_old;
  logic [11:0] w_new;

  assign w_cap = (r_state == WAIT) && cnv_cmplt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // Next-state and Moore request output
  always_comb begin
    w_nxt    = r_state;
    strt_cnv = 1'b0;
    case (r_state)
      IDLE: begin
        if (scan_en) w_nxt = START;
      end
      START: begin
        strt_cnv = 1'b1;
        w_nxt    = WAIT;
      end
      WAIT: begin
        if (cnv_cmplt) w_nxt = GAP;
      end
      GAP: begin
        if (r_gap == 16'd0) w_nxt = scan_en ? START : IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  // Gap counter: loaded at capture, counts down while in GAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap <= 16'd0;
    end else if (w_cap) begin
      r_gap <= GAP_LD;
    end else if (r_state == GAP && r_gap != 16'd0) begin
      r_gap <= r_gap - 16'd1;
    end
  end

  // Pot index advances on capture; sweep pulse after the last pot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= 3'd0;
      r_sweep <= 1'b0;
    end else begin
      r_sweep <= w_cap && (r_idx == 3'd5);
      if (w_cap) r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end
  end

  // Channel map from scan index
  always_comb begin
    chnnl = 3'd1;
    case (r_idx)
      3'd0:    chnnl = 3'd1;
      3'd1:    chnnl = 3'd0;
      3'd2:    chnnl = 3'd4;
      3'd3:    chnnl = 3'd2;
      3'd4:    chnnl = 3'd3;
      3'd5:    chnnl = 3'd7;
      default: chnnl = 3'd1;
    endcase
  end

  // Current value of the selected pot register
  always_comb begin
    w_old = 12'h000;
    case (r_idx)
      3'd0:    w_old = r_pot[0];
      3'd1:    w_old = r_pot[1];
      3'd2:    w_old = r_pot[2];
      3'd3:    w_old = r_pot[3];
      3'd4:    w_old = r_pot[4];
      3'd5:    w_old = r_pot[5];
      default: w_old = 12'h000;
    endcase
  end

`ifdef POT_SMOOTH_EN
  logic [5:0]         r_primed;
  logic               w_prm;
  logic signed [12:0] w_diff;
  logic signed [12:0] w_step;

  // Value to store: raw first sample, then old + diff/4
  always_comb begin
    w_prm  = 1'b0;
    case (r_idx)
      3'd0:    w_prm = r_primed[0];
      3'd1:    w_prm = r_primed[1];
      3'd2:    w_prm = r_primed[2];
      3'd3:    w_prm = r_primed[3];
      3'd4:    w_prm = r_primed[4];
      3'd5:    w_prm = r_primed[5];
      default: w_prm = 1'b0;
    endcase
    w_diff = $signed({1'b0, res}) - $signed({1'b0, w_old});
    w_step = w_diff >>> 2;
    w_new  = w_prm ? w_old + w_step[11:0] : res;
  end

  // Primed bits mark pots that already hold a real sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_primed <= 6'd0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (w_cap && r_idx == 3'(i)) r_primed[i] <= 1'b1;
      end
    end
  end
`else
  // Value to store: raw result
  always_comb begin
    w_new = res;
  end
`endif

  // Pot holding registers, written only on capture in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) r_pot[i] <= 12'h000;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (w_cap && r_idx == 3'(i)) r_pot[i] <= w_new;
      end
    end
  end

  assign LP_pot     = r_pot[0];
  assign B1_pot     = r_pot[1];
  assign B2_pot     = r_pot[2];
  assign B3_pot     = r_pot[3];
  assign HP_pot     = r_pot[4];
  assign volume     = r_pot[5];
  assign sweep_done = r_sweep;

endmodule

// File: tb/tb_pot_scan_seq.sv
// tb_pot_scan_seq: directed + randomized bench for pot_scan_seq.
// Reference model tracks pot values, scan index and request spacing.
module tb_pot_scan_seq;

  localparam int GAP = 4;

  logic        clk;
  logic        rst_n;
  logic        scan_en;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [11:0] LP_pot;
  logic [11:0] B1_pot;
  logic [11:0] B2_pot;
  logic [11:0] B3_pot;
  logic [11:0] HP_pot;
  logic [11:0] volume;
  logic        sweep_done;

  pot_scan_seq #(.GAP_CYCLES(GAP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .scan_en(scan_en),
    .cnv_cmplt(cnv_cmplt),
    .res(res),
    .strt_cnv(strt_cnv),
    .chnnl(chnnl),
    .LP_pot(LP_pot),
    .B1_pot(B1_pot),
    .B2_pot(B2_pot),
    .B3_pot(B3_pot),
    .HP_pot(HP_pot),
    .volume(volume),
    .sweep_done(sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          ch_map [6] = '{1, 0, 4, 2, 3, 7};
  logic [11:0] ref_pot [6];
  bit          primed [6];
  int          ref_idx;
  int          last_strt;
  int          last_lat;
  bit          space_ok;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pot_out(input int i);
    case (i)
      0:       return LP_pot;
      1:       return B1_pot;
      2:       return B2_pot;
      3:       return B3_pot;
      4:       return HP_pot;
      default: return volume;
    endcase
  endfunction

  task automatic check_pots(input string tag);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s_pot%0d", tag, i), 32'(pot_out(i)), 32'(ref_pot[i]));
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 6; i++) begin
      ref_pot[i] = 12'h000;
      primed[i]  = 1'b0;
    end
    ref_idx  = 0;
    space_ok = 1'b0;
  endtask

  task automatic ref_cap(input logic [11:0] v);
    int d;
    d = 0;
`ifdef POT_SMOOTH_EN
    if (primed[ref_idx]) begin
      d = int'(v) - int'(ref_pot[ref_idx]);
      ref_pot[ref_idx] = 12'(int'(ref_pot[ref_idx]) + (d >>> 2));
    end else begin
      ref_pot[ref_idx] = v;
    end
    primed[ref_idx] = 1'b1;
`else
    ref_pot[ref_idx] = v;
`endif
    ref_idx = (ref_idx + 1) % 6;
  endtask

  // One conversion as the SPI master would serve it: result 'lat'
  // cycles after the request; optionally drop scan_en during WAIT.
  task automatic conv(input int lat, input logic [11:0] v,
                      input bit use_v, input bit drop);
    int          n;
    logic [11:0] r;
    bit          exp_sw;
    n = 0;
    while (strt_cnv !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("strt_seen", 32'(strt_cnv), 32'd1);
    if (strt_cnv !== 1'b1) return;
    chk("chnnl", 32'(chnnl), 32'(ch_map[ref_idx]));
    if (space_ok) chk("spacing", cyc - last_strt, 1 + last_lat + GAP);
    last_strt = cyc;
    last_lat  = lat;
    r = use_v ? v : {9'h0, chnnl};
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      if (k == 0 && drop) scan_en = 1'b0;
      chk("strt_1cyc", 32'(strt_cnv), 32'd0);
      chk("chnnl_hold", 32'(chnnl), 32'(ch_map[ref_idx]));
    end
    cnv_cmplt = 1'b1;
    res       = r;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    res       = 12'($urandom);
    exp_sw    = (ref_idx == 5);
    ref_cap(r);
    check_pots("cap");
    chk("sweep", 32'(sweep_done), 32'(exp_sw));
    @(negedge clk);
    chk("sweep_1cyc", 32'(sweep_done), 32'd0);
    space_ok = 1'b1;
  endtask

  initial begin
    int          cnt;
    logic [11:0] lp_exp;
    rst_n     = 1'b0;
    scan_en   = 1'b0;
    cnv_cmplt = 1'b0;
    res       = 12'h000;
    ref_reset();
    last_strt = 0;
    last_lat  = 0;
    repeat (3) @(negedge clk);
    check_pots("rst");
    chk("rst_chnnl", 32'(chnnl), 32'd1);
    chk("rst_strt", 32'(strt_cnv), 32'd0);
    chk("rst_sweep", 32'(sweep_done), 32'd0);
    rst_n = 1'b1;

    // Idle with scan disabled: no requests
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (strt_cnv === 1'b1) cnt++;
    end
    chk("idle_no_strt", cnt, 0);

    // Two full sweeps, res = channel number, fixed latency
    scan_en = 1'b1;
    for (int i = 0; i < 12; i++) conv(10, 12'h000, 1'b0, 1'b0);

    // LP, B1, then drop scan_en during B2 WAIT
    conv(10, 12'h000, 1'b0, 1'b0);
    conv(10, 12'h000, 1'b0, 1'b0);
    conv(10, 12'hABC, 1'b1, 1'b1);
    chk("B2_abc", 32'(B2_pot), 32'hABC);
    space_ok = 1'b0;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (strt_cnv === 1'b1) cnt++;
    end
    chk("drop_no_strt", cnt, 0);

    // Stray completion while idle
    cnv_cmplt = 1'b1;
    res       = 12'hFFF;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    @(negedge clk);
    check_pots("idle_inj");
    chk("idle_inj_strt", 32'(strt_cnv), 32'd0);

    // Resume: next request must be B3 (ch2)
    scan_en = 1'b1;
    conv(10, 12'h000, 1'b0, 1'b0);

    // Stray completion during GAP
    cnv_cmplt = 1'b1;
    res       = 12'hFFF;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    check_pots("gap_inj");
    conv(10, 12'h000, 1'b0, 1'b0);

    // Randomized latency and results
    for (int i = 0; i < 12; i++)
      conv($urandom_range(1, 20), 12'($urandom), 1'b1, 1'b0);

    // Reset in the middle of the HP conversion
    while (ref_idx != 4) conv(10, 12'h000, 1'b0, 1'b0);
    cnt = 0;
    while (strt_cnv !== 1'b1 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    chk("hp_strt", 32'(strt_cnv), 32'd1);
    chk("hp_chnnl", 32'(chnnl), 32'd3);
    repeat (3) @(negedge clk);
    rst_n   = 1'b0;
    scan_en = 1'b0;
    #1;
    ref_reset();
    check_pots("mid_rst");
    chk("mid_rst_chnnl", 32'(chnnl), 32'd1);
    chk("mid_rst_strt", 32'(strt_cnv), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnv_cmplt = 1'b1;
    res       = 12'hFFF;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    @(negedge clk);
    check_pots("late_cmplt");
    chk("late_chnnl", 32'(chnnl), 32'd1);

    // LP fed 400 then 000 across a sweep
    scan_en = 1'b1;
    conv(10, 12'h400, 1'b1, 1'b0);
    chk("LP_first", 32'(LP_pot), 32'h400);
    for (int i = 0; i < 5; i++) conv(10, 12'h000, 1'b0, 1'b0);
    conv(10, 12'h000, 1'b1, 1'b0);
`ifdef POT_SMOOTH_EN
    lp_exp = 12'h300;
`else
    lp_exp = 12'h000;
`endif
    chk("LP_second", 32'(LP_pot), 32'(lp_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
